// File: rtl/axis_stream_adapter.sv
// -----------------------------------------------------------------------------
// axis_stream_adapter
//
// AXI-Stream front/back end for the neuromorphic network datapath.
//   Input side : deserialises BUS_WIDTH beats into INP_WIDTH source words for
//                network_source, with optional tlast framing checks.
//   Output side: buffers OUT_WIDTH network_sink words in a FIFO and serialises
//                each word back onto the bus, tlast on the final beat of a word.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready   narrow input bus
//   src, src_valid, src_ready          assembled source word handshake
//   snk, snk_valid, snk_ready          sink word into the output FIFO
//   m_axis_tdata/tvalid/tlast/tready   narrow output bus
//   fifo_level               words currently held in the output FIFO
//   frame_err                sticky framing error (cleared by rst only)
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module axis_stream_adapter #(
    parameter int BUS_WIDTH   = 8,
    parameter int INP_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_DEPTH   = 4,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit CHECK_TLAST = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BUS_WIDTH-1:0]           s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [INP_WIDTH-1:0]           src,
    output logic                           src_valid,
    input  logic                           src_ready,
    input  logic [OUT_WIDTH-1:0]           snk,
    input  logic                           snk_valid,
    output logic                           snk_ready,
    output logic [BUS_WIDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [$clog2(OUT_DEPTH+1)-1:0] fifo_level,
    output logic                           frame_err
);

    localparam int IN_BEATS  = INP_WIDTH / BUS_WIDTH;
    localparam int OUT_BEATS = OUT_WIDTH / BUS_WIDTH;
    // Counters keep at least one bit so single-beat words stay legal.
    localparam int ICW = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OCW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int AW  = $clog2(OUT_DEPTH);
    localparam int LW  = $clog2(OUT_DEPTH + 1);

    localparam logic [ICW-1:0] IN_LAST    = ICW'(IN_BEATS - 1);
    localparam logic [ICW-1:0] IN_ZERO    = ICW'(0);
    localparam logic [ICW-1:0] IN_ONE     = ICW'(1);
    localparam logic [OCW-1:0] OUT_LAST   = OCW'(OUT_BEATS - 1);
    localparam logic [OCW-1:0] OUT_ZERO   = OCW'(0);
    localparam logic [OCW-1:0] OUT_ONE    = OCW'(1);
    localparam logic [AW-1:0]  PTR_ZERO   = AW'(0);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
    localparam logic [LW-1:0]  LEVEL_ZERO = LW'(0);
    localparam logic [LW-1:0]  LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0]  LEVEL_FULL = LW'(OUT_DEPTH);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } in_state_t;

    // Slice of the source word that beat number k lands in.
    function automatic logic [ICW-1:0] in_slice_idx(input logic [ICW-1:0] k);
        if (MSB_FIRST) begin
            return IN_LAST - k;
        end else begin
            return k;
        end
    endfunction

    // Bus beat number k of sink word w, in the configured beat order.
    function automatic logic [BUS_WIDTH-1:0] out_slice(input logic [OUT_WIDTH-1:0] w,
                                                       input logic [OCW-1:0]       k);
        logic [OCW-1:0] idx;
        if (MSB_FIRST) begin
            idx = OUT_LAST - k;
        end else begin
            idx = k;
        end
        return w[int'(idx)*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    // ---------------------------------------------------------------- input side
    in_state_t              in_state_r;
    logic [ICW-1:0]         in_cnt_r;
    logic [INP_WIDTH-1:0]   word_r;
    logic                   src_valid_r;
    logic                   s_tready_r;
    logic                   frame_err_r;

    // Input deserialiser FSM: collect beats, then hold the word until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_r  <= ST_COLLECT;
            in_cnt_r    <= IN_ZERO;
            word_r      <= {INP_WIDTH{1'b0}};
            src_valid_r <= 1'b0;
            s_tready_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            case (in_state_r)
                ST_COLLECT: begin
                    if (s_axis_tvalid && s_tready_r) begin
                        word_r[int'(in_slice_idx(in_cnt_r))*BUS_WIDTH +: BUS_WIDTH] <= s_axis_tdata;
                        if (in_cnt_r == IN_LAST) begin
                            // Word complete; a missing tlast is flagged but the word is kept.
                            in_state_r  <= ST_HOLD;
                            in_cnt_r    <= IN_ZERO;
                            src_valid_r <= 1'b1;
                            s_tready_r  <= 1'b0;
                            if (CHECK_TLAST && !s_axis_tlast) begin
                                frame_err_r <= 1'b1;
                            end
                        end else if (CHECK_TLAST && s_axis_tlast) begin
                            // Early tlast: drop the partial word, next beat starts afresh.
                            in_cnt_r   <= IN_ZERO;
                            s_tready_r <= 1'b1;
                            frame_err_r <= 1'b1;
                        end else begin
                            in_cnt_r   <= in_cnt_r + IN_ONE;
                            s_tready_r <= 1'b1;
                        end
                    end else begin
                        s_tready_r <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (src_ready) begin
                        in_state_r  <= ST_COLLECT;
                        src_valid_r <= 1'b0;
                        s_tready_r  <= 1'b1;
                    end
                end
                default: begin
                    in_state_r  <= ST_COLLECT;
                    in_cnt_r    <= IN_ZERO;
                    src_valid_r <= 1'b0;
                    s_tready_r  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- output FIFO
    logic [OUT_WIDTH-1:0] mem_r [OUT_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic [LW-1:0]        level_next_s;
    logic                 snk_ready_r;
    logic                 push_s;
    logic                 pop_s;

    logic [OCW-1:0]       out_cnt_r;
    logic [BUS_WIDTH-1:0] m_tdata_r;
    logic                 m_tvalid_r;
    logic                 m_tlast_r;

    // snk_ready reflects the registered level, so a full FIFO never accepts a
    // word even when the head is popped in the same cycle.
    assign push_s = snk_valid && snk_ready_r;
    // The head word stays in the FIFO while it is serialised; it leaves on the
    // final beat handshake.
    assign pop_s  = m_tvalid_r && m_axis_tready && m_tlast_r;

    // Next FIFO level from the push/pop pair.
    always_comb begin
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LEVEL_ONE;
        end else if (!push_s && pop_s) begin
            level_next_s = level_r - LEVEL_ONE;
        end else begin
            level_next_s = level_r;
        end
    end

    // FIFO pointers, level and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            level_r     <= LEVEL_ZERO;
            snk_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r     <= level_next_s;
            snk_ready_r <= (level_next_s != LEVEL_FULL);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= snk;
        end
    end

    // ---------------------------------------------------------------- serialiser
    // Output serialiser: loads the head when idle, walks its beats and chains
    // straight into the following word when one is already queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_r  <= OUT_ZERO;
            m_tdata_r  <= {BUS_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end else if (!m_tvalid_r) begin
            if (level_r != LEVEL_ZERO) begin
                out_cnt_r  <= OUT_ZERO;
                m_tdata_r  <= out_slice(mem_r[rd_ptr_r], OUT_ZERO);
                m_tvalid_r <= 1'b1;
                m_tlast_r  <= (OUT_LAST == OUT_ZERO);
            end
        end else if (m_axis_tready) begin
            if (m_tlast_r) begin
                if (level_r > LEVEL_ONE) begin
                    out_cnt_r  <= OUT_ZERO;
                    m_tdata_r  <= out_slice(mem_r[rd_ptr_r + PTR_ONE], OUT_ZERO);
                    m_tvalid_r <= 1'b1;
                    m_tlast_r  <= (OUT_LAST == OUT_ZERO);
                end else begin
                    out_cnt_r  <= OUT_ZERO;
                    m_tvalid_r <= 1'b0;
                    m_tlast_r  <= 1'b0;
                end
            end else begin
                out_cnt_r <= out_cnt_r + OUT_ONE;
                m_tdata_r <= out_slice(mem_r[rd_ptr_r], out_cnt_r + OUT_ONE);
                m_tlast_r <= ((out_cnt_r + OUT_ONE) == OUT_LAST);
            end
        end
    end

    assign s_axis_tready = s_tready_r;
    assign src           = word_r;
    assign src_valid     = src_valid_r;
    assign snk_ready     = snk_ready_r;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;
    assign fifo_level    = level_r;
    assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_axis_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_adapter
//
// Directed bench for axis_stream_adapter. dut uses the default parameters
// (MSB first), dut2 uses MSB_FIRST=0 and has its own reset.
// -----------------------------------------------------------------------------
module tb_axis_stream_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [31:0] src;
    logic        src_valid, src_ready = 1'b0;
    logic [15:0] snk = 16'h0000;
    logic        snk_valid = 1'b0, snk_ready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready = 1'b0;
    logic [2:0]  fifo_level;
    logic        frame_err;

    logic        rst2 = 1'b1;
    logic [7:0]  s_tdata2 = 8'h00;
    logic        s_tvalid2 = 1'b0, s_tlast2 = 1'b0, s_tready2;
    logic [31:0] src2;
    logic        src_valid2, src_ready2 = 1'b1;
    logic [15:0] snk2 = 16'h0000;
    logic        snk_valid2 = 1'b0, snk_ready2;
    logic [7:0]  m_tdata2;
    logic        m_tvalid2, m_tlast2, m_tready2 = 1'b0;
    logic [2:0]  fifo_level2;
    logic        frame_err2;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    logic [31:0] hs_word = 32'h0;

    always #5 clk = ~clk;

    axis_stream_adapter dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .src(src), .src_valid(src_valid), .src_ready(src_ready),
        .snk(snk), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .fifo_level(fifo_level), .frame_err(frame_err)
    );

    axis_stream_adapter #(.MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst2),
        .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2), .s_axis_tlast(s_tlast2),
        .s_axis_tready(s_tready2),
        .src(src2), .src_valid(src_valid2), .src_ready(src_ready2),
        .snk(snk2), .snk_valid(snk_valid2), .snk_ready(snk_ready2),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2),
        .m_axis_tready(m_tready2),
        .fifo_level(fifo_level2), .frame_err(frame_err2)
    );

    typedef struct {
        int          n;
        logic [47:0] beats;    // beat 0 in [47:40]
        logic [5:0]  last;     // bit i = tlast on beat i
        logic [31:0] exp_src;
        logic        exp_err;
    } in_vec_t;

    in_vec_t     vecs [5];
    logic [15:0] words [5];
    logic [8:0]  exp_beats [10];   // {tlast, tdata}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: note source handshakes of dut, then move to #1 after the edge.
    task automatic step();
        if (src_valid && src_ready) begin
            hs_cnt++;
            hs_word = src;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic send1(input logic [47:0] beats, input int n, input logic [5:0] last);
        for (int i = 0; i < n; i++) begin
            s_tdata  = beats[47-8*i -: 8];
            s_tlast  = last[i];
            s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send2(input logic [31:0] beats, input int n, input bit last_final);
        for (int i = 0; i < n; i++) begin
            s_tdata2  = beats[31-8*i -: 8];
            s_tlast2  = last_final && (i == n - 1);
            s_tvalid2 = 1'b1;
            step();
        end
        s_tvalid2 = 1'b0;
        s_tlast2  = 1'b0;
    endtask

    task automatic run_stream(input bit toggle);
        logic [8:0] got [$];
        int         cyc_first, cyc_last, k;
        logic       stall_prev;
        logic [8:0] stall_val;
        bit         pushed5;
        cyc_first = 0;
        cyc_last  = 0;
        reset_dut();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            snk = words[i];
            snk_valid = 1'b1;
            step();
            check("fifo_level_push", 64'(fifo_level), 64'(i + 1));
        end
        check("snk_ready_full", 64'(snk_ready), 64'd0);
        check("head_loaded", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b0, 8'h12}));
        snk = words[4];
        snk_valid = 1'b1;
        pushed5 = 1'b0;
        stall_prev = 1'b0;
        stall_val = 9'h0;
        k = 0;
        while (got.size() < 10 && k < 60) begin
            m_tready = toggle ? (k % 2 == 0) : 1'b1;
            if (stall_prev) begin
                check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, stall_val}));
            end
            if (m_tvalid && m_tready) begin
                got.push_back({m_tlast, m_tdata});
                if (got.size() == 1) cyc_first = k;
                cyc_last = k;
            end
            if (snk_valid && snk_ready) pushed5 = 1'b1;
            stall_prev = m_tvalid && !m_tready;
            stall_val  = {m_tlast, m_tdata};
            step();
            k++;
            if (pushed5) snk_valid = 1'b0;
        end
        snk_valid = 1'b0;
        m_tready = 1'b0;
        check("beat_count", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size() && i < 10; i++) begin
            check("beat", 64'(got[i]), 64'(exp_beats[i]));
        end
        if (!toggle) begin
            check("no_bubble", 64'(cyc_last - cyc_first), 64'd9);
        end
        check("fifth_pushed", 64'(pushed5), 64'd1);
        step();
        check("drained", 64'({fifo_level, m_tvalid, snk_ready}), 64'({3'd0, 1'b0, 1'b1}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        vecs[0] = '{4, 48'hDEADBEEF0000, 6'b001000, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{6, 48'h1122AABBCCDD, 6'b100010, 32'hAABBCCDD, 1'b1};
        vecs[2] = '{4, 48'h010203040000, 6'b000000, 32'h01020304, 1'b1};
        vecs[3] = '{5, 48'hA01020304000, 6'b010001, 32'h10203040, 1'b1};
        vecs[4] = '{4, 48'h123456780000, 6'b001000, 32'h12345678, 1'b0};
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        words[3] = 16'hDEF0; words[4] = 16'h0F0F;
        exp_beats[0] = {1'b0, 8'h12}; exp_beats[1] = {1'b1, 8'h34};
        exp_beats[2] = {1'b0, 8'h56}; exp_beats[3] = {1'b1, 8'h78};
        exp_beats[4] = {1'b0, 8'h9A}; exp_beats[5] = {1'b1, 8'hBC};
        exp_beats[6] = {1'b0, 8'hDE}; exp_beats[7] = {1'b1, 8'hF0};
        exp_beats[8] = {1'b0, 8'h0F}; exp_beats[9] = {1'b1, 8'h0F};

        // Reset state and ready release.
        step();
        step();
        check("reset_outputs", 64'({s_tready, src_valid, snk_ready, m_tvalid, m_tlast, fifo_level, frame_err}), 64'd0);
        check("reset_src_tdata", 64'({src, m_tdata}), 64'd0);
        rst  = 1'b0;
        rst2 = 1'b0;
        check("tready_before_edge", 64'(s_tready), 64'd0);
        step();
        check("ready_after_reset", 64'({s_tready, snk_ready}), 64'({1'b1, 1'b1}));

        // Table of input word transactions.
        for (int v = 0; v < 5; v++) begin
            reset_dut();
            src_ready = 1'b1;
            base = hs_cnt;
            send1(vecs[v].beats, vecs[v].n, vecs[v].last);
            check("src_valid_rise", 64'({src_valid, s_tready}), 64'({1'b1, 1'b0}));
            check("src_word", 64'(src), 64'(vecs[v].exp_src));
            check("frame_err", 64'(frame_err), 64'(vecs[v].exp_err));
            step();
            check("src_released", 64'({src_valid, s_tready}), 64'({1'b0, 1'b1}));
            check("src_word_count", 64'(hs_cnt - base), 64'd1);
            check("src_hs_word", 64'(hs_word), 64'(vecs[v].exp_src));
        end

        // Back-pressure on src: word held, no beat accepted.
        reset_dut();
        src_ready = 1'b0;
        base = hs_cnt;
        send1(48'hCAFEBABE0000, 4, 6'b001000);
        s_tdata  = 8'h55;
        s_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_state", 64'({src_valid, s_tready}), 64'({1'b1, 1'b0}));
            check("hold_src", 64'(src), 64'h00000000CAFEBABE);
            step();
        end
        s_tvalid  = 1'b0;
        src_ready = 1'b1;
        step();
        check("hold_release", 64'({src_valid, s_tready, 32'(hs_cnt - base)}), 64'({1'b0, 1'b1, 32'd1}));
        send1(48'h010203040000, 4, 6'b001000);
        check("after_hold_word", 64'({src_valid, src}), 64'({1'b1, 32'h01020304}));
        step();

        // Output FIFO and serialiser, steady ready then 1,0,1,0 ready.
        run_stream(1'b0);
        run_stream(1'b1);

        // LSB-first instance plus reset mid-word / mid-serialisation.
        send2(32'hEFBEADDE, 4, 1'b1);
        check("lsb_src", 64'({src_valid2, src2}), 64'({1'b1, 32'hDEADBEEF}));
        step();
        snk2 = 16'hABCD;
        snk_valid2 = 1'b1;
        step();
        snk2 = 16'h1357;
        step();
        snk_valid2 = 1'b0;
        check("lsb_level", 64'(fifo_level2), 64'd2);
        check("lsb_first_beat", 64'({m_tvalid2, m_tlast2, m_tdata2}), 64'({1'b1, 1'b0, 8'hCD}));
        send2(32'h01020000, 2, 1'b0);
        rst2 = 1'b1;
        step();
        check("rst2_outputs", 64'({s_tready2, src_valid2, snk_ready2, m_tvalid2, m_tlast2, fifo_level2, frame_err2}), 64'd0);
        check("rst2_data", 64'({src2, m_tdata2}), 64'd0);
        step();
        rst2 = 1'b0;
        m_tready2 = 1'b1;
        step();
        check("rst2_release", 64'({s_tready2, m_tvalid2, fifo_level2}), 64'({1'b1, 1'b0, 3'd0}));
        send2(32'h01020304, 4, 1'b1);
        check("rst2_fresh_word", 64'({src_valid2, src2}), 64'({1'b1, 32'h04030201}));
        check("rst2_no_emit", 64'({m_tvalid2, frame_err2}), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
